// File: rtl/ppu_scroll_regs.sv
// PPU VRAM address state: current address v, home address t, fine X.
// Applies CPU reloads/increments and renderer scroll increments/copies.
//
// Ports:
//   clk, rst_n         dot clock, async active-low reset
//   x_i, y_i           current dot / scanline
//   render_en_i        background or sprite rendering enabled
//   home_addr_i/_we_i  new t value and its write strobe
//   reset_to_home_i    load v from home_addr_i
//   inc_1_i, inc_32_i  CPU PPUDATA access steps
//   fine_x_i/_we_i     new fine X and its write strobe
//   home_addr_o        t
//   vram_addr_o        v
//   fine_x_o           fine X
//   nt_addr_o          nametable byte address
//   at_addr_o          attribute byte address
//   attr_sel_o         attribute quadrant select
module ppu_scroll_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  x_i,
    input  logic [8:0]  y_i,
    input  logic        render_en_i,
    input  logic [14:0] home_addr_i,
    input  logic        home_addr_we_i,
    input  logic        reset_to_home_i,
    input  logic        inc_1_i,
    input  logic        inc_32_i,
    input  logic [2:0]  fine_x_i,
    input  logic        fine_x_we_i,
    output logic [14:0] home_addr_o,
    output logic [14:0] vram_addr_o,
    output logic [2:0]  fine_x_o,
    output logic [13:0] nt_addr_o,
    output logic [13:0] at_addr_o,
    output logic [1:0]  attr_sel_o
);

    logic [14:0] t;
    logic [14:0] v;
    logic [14:0] v_nxt;
    logic [2:0]  fx;

    logic active;
    logic inc_any;
    logic tile_dot;
    logic vert_copy;

    // Coarse X step; wrapping past 31 flips the horizontal nametable.
    function automatic logic [14:0] cx(input logic [14:0] a);
        logic [14:0] r;
        r = a;
        if (a[4:0] == 5'd31) begin
            r[4:0] = 5'd0;
            r[10]  = ~a[10];
        end else begin
            r[4:0] = a[4:0] + 5'd1;
        end
        return r;
    endfunction

    // Y step; row 29 is the last visible tile row and flips the vertical
    // nametable, rows 30/31 hold attributes and wrap without a flip.
    function automatic logic [14:0] yi(input logic [14:0] a);
        logic [14:0] r;
        r = a;
        if (a[14:12] != 3'd7) begin
            r[14:12] = a[14:12] + 3'd1;
        end else begin
            r[14:12] = 3'd0;
            if (a[9:5] == 5'd29) begin
                r[9:5] = 5'd0;
                r[11]  = ~a[11];
            end else if (a[9:5] == 5'd31) begin
                r[9:5] = 5'd0;
            end else begin
                r[9:5] = a[9:5] + 5'd1;
            end
        end
        return r;
    endfunction

    assign active  = render_en_i && ((y_i < 9'd240) || (y_i == 9'd261));
    assign inc_any = inc_1_i || inc_32_i;

    // Tile fetch boundaries: 8..248 and the two prefetch tiles 328/336.
    assign tile_dot = (x_i[2:0] == 3'd0) &&
                      (((x_i >= 9'd8) && (x_i <= 9'd248)) ||
                       (x_i == 9'd328) || (x_i == 9'd336));

    assign vert_copy = render_en_i && (y_i == 9'd261) &&
                       (x_i >= 9'd280) && (x_i <= 9'd304);

    always_comb begin
        v_nxt = v;
        if (reset_to_home_i) begin
            v_nxt = home_addr_i;
        end else if (inc_any && !active) begin
            v_nxt = inc_32_i ? (v + 15'd32) : (v + 15'd1);
        end else if (inc_any) begin
            // CPU access while rendering glitches both scroll counters.
            v_nxt = yi(cx(v));
        end else if (active && (x_i == 9'd256)) begin
            v_nxt = yi(cx(v));
        end else if (active && tile_dot) begin
            v_nxt = cx(v);
        end else if (active && (x_i == 9'd257)) begin
            v_nxt[10]  = t[10];
            v_nxt[4:0] = t[4:0];
        end else if (vert_copy) begin
            v_nxt[14:11] = t[14:11];
            v_nxt[9:5]   = t[9:5];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t  <= 15'd0;
            v  <= 15'd0;
            fx <= 3'd0;
        end else begin
            if (home_addr_we_i) t <= home_addr_i;
            if (fine_x_we_i) fx <= fine_x_i;
            v <= v_nxt;
        end
    end

    assign home_addr_o = t;
    assign vram_addr_o = v;
    assign fine_x_o    = fx;
    assign nt_addr_o   = {2'b10, v[11:0]};
    assign at_addr_o   = {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]};
    assign attr_sel_o  = {v[6], v[1]};

endmodule
